// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single bus controller.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_arbiter (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_read,
  input  logic [1:0]  i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store,
  input  logic        i_done,
  output logic        i_ready,
  output logic [31:0] i_load,
  input  logic        d_read,
  input  logic [1:0]  d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_store,
  input  logic        d_done,
  output logic        d_ready,
  output logic [31:0] d_load,
  output logic        m_read,
  output logic [1:0]  m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_store,
  output logic        m_done,
  input  logic        m_ready,
  input  logic [31:0] m_load,
  output logic [1:0]  gnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rd_q, rd_d;
  logic [1:0]  wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        i_pend, d_pend, pick_d, done_sel, busy;
`ifdef ARB_ROUND_ROBIN_EN
  logic        ptr_q, ptr_d;  // 1: instruction side was granted most recently
`endif

  assign i_pend = i_read | (|i_write);
  assign d_pend = d_read | (|d_write);
  assign busy   = (state_q == BUSY);

  always_comb begin
    done_sel = 1'b0;
    if (gnt_q == GNT_I)      done_sel = i_done;
    else if (gnt_q == GNT_D) done_sel = d_done;
  end

  assign m_done  = busy & m_ready & done_sel;
  assign i_ready = busy & m_ready & (gnt_q == GNT_I);
  assign d_ready = busy & m_ready & (gnt_q == GNT_D);
  assign i_load  = m_load;
  assign d_load  = m_load;
  assign m_read  = rd_q;
  assign m_write = wr_q;
  assign m_addr  = addr_q;
  assign m_store = store_q;
  assign gnt     = gnt_q;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = (i_pend & d_pend) ? ptr_q : d_pend;
`else
  assign pick_d = d_pend;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    store_d = store_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_pend | d_pend) begin
          state_d = BUSY;
          gnt_d   = pick_d ? GNT_D : GNT_I;
          rd_d    = pick_d ? d_read : i_read;
          // A simultaneous read and write is treated as a plain read.
          wr_d    = rd_d ? 2'b00 : (pick_d ? d_write : i_write);
          addr_d  = pick_d ? d_addr : i_addr;
          store_d = pick_d ? d_store : i_store;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = ~pick_d;
`endif
        end
      end
      BUSY: begin
        // Returning to IDLE for a cycle lets the controller drop its result.
        if (m_done) begin
          state_d = IDLE;
          gnt_d   = GNT_NONE;
          rd_d    = 1'b0;
          wr_d    = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_NONE;
      rd_q    <= 1'b0;
      wr_q    <= 2'b00;
      addr_q  <= 32'd0;
      store_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      store_q <= store_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports (name direction width meaning):
  clk  in  1  clock
  nrst  in  1  reset, synchronous, active-low
  i_read  in  1  instruction-side read request
  i_write  in  2  instr write size (00 none, 01 byte, 10 half, 11 word)
  i_addr  in  32  instr byte address
  i_store  in  32  instr write data
  i_done  in  1  instr requester consumed result
  i_ready  out  1  instr result valid
  i_load  out  32  instr read data
  d_read, d_write, d_addr, d_store, d_done, d_ready, d_load  same widths/directions, data-side
  m_read  out  1  read request to bus controller
  m_write  out  2  write size to bus controller
  m_addr  out  32  address to bus controller
  m_store  out  32  write data to bus controller
  m_done  out  1  completion ack to bus controller
  m_ready  in  1  bus controller result valid (registered, held until done)
  m_load  in  32  bus controller read data
  gnt  out  2  current owner (00 none, 01 instr, 10 data)

Function
REQ-002 SHALL implement two states: IDLE, BUSY.
REQ-003 Requester "pending" SHALL mean read=1 or write!=00.
REQ-004 In IDLE with >=1 pending requester, SHALL select a winner, latch its read, write, addr, store into registers, set gnt, enter BUSY next edge.
REQ-005 If winner asserts read and write together, SHALL latch read=1, write=00 (read wins).
REQ-006 m_read, m_write, m_addr, m_store SHALL be driven only from latched registers; zero (read/write) in IDLE; addr/store hold last value.
REQ-007 Latency: request sampled in IDLE at edge N -> m_read/m_write high from cycle N+1.
REQ-008 Requester inputs SHALL be ignored while BUSY (latched values hold for whole transaction).
REQ-009 i_ready SHALL equal m_ready AND gnt==01 AND BUSY; d_ready likewise with gnt==10; combinational.
REQ-010 i_load and d_load SHALL both equal m_load (valid only with respective ready).
REQ-011 m_done SHALL equal granted requester's done AND m_ready AND BUSY; ungranted done ignored.
REQ-012 BUSY->IDLE SHALL occur at edge where m_done=1; at that edge latched read/write cleared, gnt -> 00.
REQ-013 Done with m_ready=0 SHALL be ignored (state stays BUSY).
REQ-014 No new grant in the cycle following completion: arbiter spends >=1 cycle in IDLE with m_read=m_write=0 so controller returns to idle cleanly.
REQ-015 Requester still pending in IDLE after its done SHALL be treated as a new request.
REQ-016 Unused downstream: no response from m_ready while IDLE SHALL affect any output.

Reset
REQ-017 On nrst=0 at clk edge: state IDLE, gnt=00, m_read=0, m_write=00, m_addr=0, m_store=0, priority pointer = instr-last.
REQ-018 Reset mid-BUSY SHALL abandon transaction without asserting m_done or i_ready/d_ready afterward.

Configuration
REQ-019 Macro ARB_ROUND_ROBIN_EN: defined -> on simultaneous pending, winner is requester not granted most recently; pointer updated on every grant.
REQ-020 Macro undefined -> fixed priority, data side always wins ties; pointer absent.
REQ-021 Single requester pending SHALL be granted in both builds.

Verification
REQ-022 After reset: gnt=00, m_read=0, m_write=00, m_addr=0, all ready outputs 0.
REQ-023 d_read=1, d_addr=0x1000 at cycle 0 -> m_read=1, m_addr=0x1000, gnt=10 cycle 1; m_ready=1, m_load=0xDEADBEEF cycle 4 -> d_ready=1, d_load=0xDEADBEEF; d_done=1 -> m_done=1, gnt=00 next cycle.
REQ-024 i_read and d_write=11 (addr 0x2004, store 0x12345678) same cycle: without macro gnt=10, m_write=11, m_store=0x12345678 first; with macro first tie -> data, second tie -> instr.
REQ-025 During data grant, i_done=1 and change d_addr to 0x3000 -> m_done=0, m_addr stays 0x2004, i_ready=0.
REQ-026 d_done=1 while m_ready=0 -> stays BUSY, m_done=0; then m_ready=1 -> completes.
REQ-027 nrst=0 during BUSY with m_ready=1 -> next cycle gnt=00, m_read=0, d_ready=0.
